// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 3;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_e;

    // Pipeline control bundle, in the order the top drives it out.
    typedef struct packed {
        logic pc_enable;
        logic if_id_enable;
        logic if_id_flush;
        logic id_ex_enable;
        logic id_ex_flush;
    } hz_ctl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX register fields and events in, pipeline
// enables/flushes out. HAZARD_PERF_EN adds the stall/flush cycle counters.
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rt;
    logic             redirect;
    logic             mem_busy;

    logic             pc_enable;
    logic             if_id_enable;
    logic             if_id_flush;
    logic             id_ex_enable;
    logic             id_ex_flush;
`ifdef HAZARD_PERF_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      flush_cycles;
`endif

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, redirect, mem_busy,
        input  pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush
`ifdef HAZARD_PERF_EN
        , input stall_cycles, flush_cycles
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, redirect, mem_busy,
        output pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush
`ifdef HAZARD_PERF_EN
        , output stall_cycles, flush_cycles
`endif
    );

endinterface

// File: rtl/hazard_load_use_cmp.sv
// Combinational load-use detector: the load in EX writes a register the
// instruction in ID reads. Register 0 never creates a dependency.
module hazard_load_use_cmp
    import hazard_pkg::*;
(
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             load_use
);

    assign load_use = ex_mem_read & (ex_rt != REG_ZERO) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// IF/ID + PC + ID/EX hazard controller for the 5-stage pipeline.
// Mealy outputs; RUN/STALL/FLUSH FSM with a down-counter sequencing
// multi-cycle stalls and multi-slot flushes.
// Optional: define HAZARD_PERF_EN for saturating stall/flush cycle counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned LOAD_LATENCY   = 1,
    parameter int unsigned REDIRECT_SLOTS = 1
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_LATENCY - 1);
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(REDIRECT_SLOTS - 1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    hz_ctl_t          ctl;

    hazard_load_use_cmp u_cmp (
        .ex_mem_read (hz.ex_mem_read),
        .ex_rt       (hz.ex_rt),
        .id_rs       (hz.id_rs),
        .id_rt       (hz.id_rt),
        .id_uses_rt  (hz.id_uses_rt),
        .load_use    (load_use)
    );

    // State and counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a frozen memory holds everything; redirect beats load-use
    // and restarts the flush window from any state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!hz.mem_busy) begin
            if (hz.redirect) begin
                if (REDIRECT_SLOTS > 1) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_RELOAD;
                end else begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end else begin
                unique case (state_q)
                    RUN: begin
                        if (load_use && LOAD_LATENCY > 1) begin
                            state_d = STALL;
                            cnt_d   = STALL_RELOAD;
                        end
                    end
                    STALL, FLUSH: begin
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = RUN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    // Outputs: reset and memory freeze force everything off; the STALL
    // outputs ignore load_use since EX already holds the bubble.
    always_comb begin
        ctl = '0;
        if (!reset || hz.mem_busy) begin
            ctl = '0;
        end else if (hz.redirect) begin
            ctl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        end else begin
            unique case (state_q)
                RUN:     ctl = load_use ? '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1}
                                        : '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
                STALL:   ctl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
                FLUSH:   ctl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
                default: ctl = '0;
            endcase
        end
    end

    assign hz.pc_enable    = ctl.pc_enable;
    assign hz.if_id_enable = ctl.if_id_enable;
    assign hz.if_id_flush  = ctl.if_id_flush;
    assign hz.id_ex_enable = ctl.id_ex_enable;
    assign hz.id_ex_flush  = ctl.id_ex_flush;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q, flush_q;
    // With reset high and memory ready, a held PC can only mean a load stall.
    wire stall_evt = reset & ~hz.mem_busy & ~ctl.pc_enable;

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt && stall_q != 32'hFFFF_FFFF)       stall_q <= stall_q + 32'd1;
            if (ctl.if_id_flush && flush_q != 32'hFFFF_FFFF) flush_q <= flush_q + 32'd1;
        end
    end

    assign hz.stall_cycles = stall_q;
    assign hz.flush_cycles = flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three parameterisations share one stimulus
// set; each scenario checks the instance whose parameters it targets.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] rs = '0, rt = '0, ex_rt = '0;
    logic       uses_rt = 1'b0, mr = 1'b0, redir = 1'b0, busy = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush}
    localparam logic [4:0] RUNO = 5'b11010;
    localparam logic [4:0] STL  = 5'b00011;
    localparam logic [4:0] RED  = 5'b11111;
    localparam logic [4:0] FLO  = 5'b11110;
    localparam logic [4:0] ZRO  = 5'b00000;

    always #5 clk = ~clk;

    hazard_ctrl_if if1 ();
    hazard_ctrl_if if3 ();
    hazard_ctrl_if if4 ();

    assign if1.id_rs = rs;  assign if1.id_rt = rt;  assign if1.id_uses_rt = uses_rt;
    assign if1.ex_mem_read = mr; assign if1.ex_rt = ex_rt;
    assign if1.redirect = redir; assign if1.mem_busy = busy;
    assign if3.id_rs = rs;  assign if3.id_rt = rt;  assign if3.id_uses_rt = uses_rt;
    assign if3.ex_mem_read = mr; assign if3.ex_rt = ex_rt;
    assign if3.redirect = redir; assign if3.mem_busy = busy;
    assign if4.id_rs = rs;  assign if4.id_rt = rt;  assign if4.id_uses_rt = uses_rt;
    assign if4.ex_mem_read = mr; assign if4.ex_rt = ex_rt;
    assign if4.redirect = redir; assign if4.mem_busy = busy;

    hazard_ctrl #(.LOAD_LATENCY(1), .REDIRECT_SLOTS(1)) d1 (.clk(clk), .reset(reset), .hz(if1));
    hazard_ctrl #(.LOAD_LATENCY(3), .REDIRECT_SLOTS(2)) d3 (.clk(clk), .reset(reset), .hz(if3));
    hazard_ctrl #(.LOAD_LATENCY(4), .REDIRECT_SLOTS(1)) d4 (.clk(clk), .reset(reset), .hz(if4));

    wire [4:0] o1 = {if1.pc_enable, if1.if_id_enable, if1.if_id_flush, if1.id_ex_enable, if1.id_ex_flush};
    wire [4:0] o3 = {if3.pc_enable, if3.if_id_enable, if3.if_id_flush, if3.id_ex_enable, if3.id_ex_flush};
    wire [4:0] o4 = {if4.pc_enable, if4.if_id_enable, if4.if_id_flush, if4.id_ex_enable, if4.id_ex_flush};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs = '0; rt = '0; ex_rt = '0; uses_rt = 1'b0;
        mr = 1'b0; redir = 1'b0; busy = 1'b0;
    endtask

    task automatic load_rs8();
        mr = 1'b1; ex_rt = 5'd8; rs = 5'd8;
    endtask

    initial begin
        idle();
        #2;
        chk("rst_d1", o1, ZRO);
        chk("rst_d3", o3, ZRO);
        chk("rst_d4", o4, ZRO);
`ifdef HAZARD_PERF_EN
        chk("rst_stall_cnt", if3.stall_cycles, 32'd0);
        chk("rst_flush_cnt", if3.flush_cycles, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        tick();
        #3 chk("idle_d1", o1, RUNO);
        tick();

        // rs load-use pulse: stall length tracks LOAD_LATENCY per instance
        for (int c = 0; c < 5; c++) begin
            if (c == 0) load_rs8(); else idle();
            #3;
            chk($sformatf("lu_d1_c%0d", c), o1, (c == 0) ? STL : RUNO);
            chk($sformatf("lu_d3_c%0d", c), o3, (c < 3) ? STL : RUNO);
            chk($sformatf("lu_d4_c%0d", c), o4, (c < 4) ? STL : RUNO);
            tick();
        end

        // load to r0 is never a hazard
        mr = 1'b1; ex_rt = 5'd0; rs = 5'd0;
        #3;
        chk("r0_d1", o1, RUNO);
        chk("r0_d3", o3, RUNO);
        tick();

        // rt match with id_uses_rt
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin
                idle(); mr = 1'b1; ex_rt = 5'd9; rt = 5'd9; uses_rt = 1'b1; rs = 5'd3;
            end else idle();
            #3;
            chk($sformatf("rt_d3_c%0d", c), o3, (c < 3) ? STL : RUNO);
            tick();
        end
        // same match but rt not a source
        mr = 1'b1; ex_rt = 5'd9; rt = 5'd9; uses_rt = 1'b0; rs = 5'd3;
        #3;
        chk("rt_nouse_d3", o3, RUNO);
        chk("rt_nouse_d1", o1, RUNO);
        tick();
        idle();
        tick(); tick(); tick();

        // single redirect
        for (int c = 0; c < 3; c++) begin
            redir = (c == 0);
            #3;
            chk($sformatf("rd_d3_c%0d", c), o3, (c == 0) ? RED : (c == 1) ? FLO : RUNO);
            chk($sformatf("rd_d1_c%0d", c), o1, (c == 0) ? RED : RUNO);
            tick();
        end

        // back-to-back redirect restarts the flush window
        for (int c = 0; c < 4; c++) begin
            redir = (c < 2);
            #3;
            chk($sformatf("rd2_d3_c%0d", c), o3, (c < 2) ? RED : (c == 2) ? FLO : RUNO);
            tick();
        end

        // priority: memory freeze over redirect and load-use, state held
        for (int c = 0; c < 6; c++) begin
            idle();
            case (c)
                0, 1: begin busy = 1'b1; redir = 1'b1; load_rs8(); end
                2:    begin redir = 1'b1; load_rs8(); end
                3:    busy = 1'b1;
                default: ;
            endcase
            #3;
            chk($sformatf("pri_d3_c%0d", c), o3,
                (c < 2 || c == 3) ? ZRO : (c == 2) ? RED : (c == 4) ? FLO : RUNO);
            if (c == 0) chk("pri_d1_c0", o1, ZRO);
            tick();
        end
        idle();
        tick(); tick(); tick(); tick(); tick();

        // redirect in the 2nd stall cycle aborts the stall
        for (int c = 0; c < 4; c++) begin
            idle();
            if (c == 0) load_rs8();
            if (c == 1) redir = 1'b1;
            #3;
            chk($sformatf("srd_d4_c%0d", c), o4, (c == 0) ? STL : (c == 1) ? RED : RUNO);
            tick();
        end
        idle();
        tick(); tick();

        // reset during FLUSH
        redir = 1'b1;
        #3 chk("rf_red_d3", o3, RED);
        tick();
        idle();
        #1 chk("rf_flush_d3", o3, FLO);
        #1 reset = 1'b0;
        #1;
        chk("rf_async_d3", o3, ZRO);
        chk("rf_async_d4", o4, ZRO);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        #3;
        chk("rf_after_d3", o3, RUNO);
        chk("rf_after_d1", o1, RUNO);
`ifdef HAZARD_PERF_EN
        chk("rf_stall_cnt", if3.stall_cycles, 32'd0);
        chk("rf_flush_cnt", if3.flush_cycles, 32'd0);
`endif
        tick();

`ifdef HAZARD_PERF_EN
        // 3 stall cycles then a 2-slot flush
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c == 0) load_rs8();
            if (c == 3) redir = 1'b1;
            tick();
        end
        chk("perf_stall_cnt", if3.stall_cycles, 32'd3);
        chk("perf_flush_cnt", if3.flush_cycles, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
